// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding descriptor pipeline.
// A descriptor is {we, wa, tNew, wd}; the bubble is the all-zero descriptor.
package hazard_pkg;

  localparam int TNEW_W    = 5;
  localparam int TNEW_LINK = 0;
  localparam int TNEW_ALU  = 1;
  localparam int TNEW_LOAD = 2;

  typedef struct packed {
    logic              we;
    logic [4:0]        wa;
    logic [TNEW_W-1:0] tnew;
    logic [31:0]       wd;
  } stage_desc_t;

  localparam stage_desc_t BUBBLE = '0;

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline descriptor register: bubble select, optional saturating tNew
// decrement, and a data mux that keeps the earlier value once tNew has hit 0.
module hazard_stage_reg #(
  parameter int TNEW_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bubble,
  input  logic              dec_en,
  input  logic              prev_we,
  input  logic [4:0]        prev_wa,
  input  logic [TNEW_W-1:0] prev_tnew,
  input  logic [31:0]       wdPrev,
  input  logic [31:0]       wdStage,
  output logic              we,
  output logic [4:0]        wa,
  output logic [TNEW_W-1:0] tnew,
  output logic [31:0]       wd
);
  import hazard_pkg::*;

  logic [TNEW_W-1:0] tnew_next;
  logic [31:0]       wd_next;

  always_comb begin
    tnew_next = prev_tnew;
    if (dec_en && (prev_tnew != '0)) tnew_next = prev_tnew - TNEW_W'(1);
    // A value that already existed upstream must not be replaced by this stage's result.
    wd_next = (prev_tnew == TNEW_W'(TNEW_LINK)) ? wdPrev : wdStage;
  end

  always_ff @(posedge clk) begin
    if (!reset || bubble) begin
      we   <= 1'b0;
      wa   <= 5'd0;
      tnew <= '0;
      wd   <= 32'd0;
    end else begin
      we   <= prev_we;
      wa   <= prev_wa;
      tnew <= tnew_next;
      wd   <= wd_next;
    end
  end

endmodule

// File: rtl/hazard_info_pipe.sv
// Producer side of the hazard interface: carries register-write descriptors
// through IdToEx, ExToMem and MemToWb and drives the GRF write port from WB.
module hazard_info_pipe #(
  parameter int TNEW_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifStall,
  input  logic              ifFlush,
  input  logic              ifWrGrf_Id,
  input  logic [4:0]        grfWa_Id,
  input  logic [TNEW_W-1:0] tNew_Id,
  input  logic [31:0]       grfWd_Id,
  input  logic [31:0]       aluOut_Ex,
  input  logic [31:0]       dmOut_Mem,
  output logic              ifWrGrf_IdToEx,
  output logic              ifWrGrf_ExToMem,
  output logic              ifWrGrf_MemToWb,
  output logic [4:0]        grfWa_IdToEx,
  output logic [4:0]        grfWa_ExToMem,
  output logic [4:0]        grfWa_MemToWb,
  output logic [TNEW_W-1:0] tNew_IdToEx,
  output logic [TNEW_W-1:0] tNew_ExToMem,
  output logic [TNEW_W-1:0] tNew_MemToWb,
  output logic [31:0]       grfWd_IdToEx,
  output logic [31:0]       grfWd_ExToMem,
  output logic [31:0]       grfWd_MemToWb,
  output logic              grfWe_Wb,
  output logic [4:0]        grfWa_Wb,
  output logic [31:0]       grfWd_Wb
);

  logic id_bubble;
  logic id_we;

  assign id_bubble = ifStall | ifFlush;
  // $0 is never a real destination, so drop its write enable on entry.
  assign id_we     = ifWrGrf_Id & (grfWa_Id != 5'd0);

  hazard_stage_reg #(.TNEW_W(TNEW_W)) u_id_to_ex (
    .clk(clk), .reset(reset), .bubble(id_bubble), .dec_en(1'b0),
    .prev_we(id_we), .prev_wa(grfWa_Id), .prev_tnew(tNew_Id),
    .wdPrev(grfWd_Id), .wdStage(grfWd_Id),
    .we(ifWrGrf_IdToEx), .wa(grfWa_IdToEx), .tnew(tNew_IdToEx), .wd(grfWd_IdToEx)
  );

  hazard_stage_reg #(.TNEW_W(TNEW_W)) u_ex_to_mem (
    .clk(clk), .reset(reset), .bubble(1'b0), .dec_en(1'b1),
    .prev_we(ifWrGrf_IdToEx), .prev_wa(grfWa_IdToEx), .prev_tnew(tNew_IdToEx),
    .wdPrev(grfWd_IdToEx), .wdStage(aluOut_Ex),
    .we(ifWrGrf_ExToMem), .wa(grfWa_ExToMem), .tnew(tNew_ExToMem), .wd(grfWd_ExToMem)
  );

  hazard_stage_reg #(.TNEW_W(TNEW_W)) u_mem_to_wb (
    .clk(clk), .reset(reset), .bubble(1'b0), .dec_en(1'b1),
    .prev_we(ifWrGrf_ExToMem), .prev_wa(grfWa_ExToMem), .prev_tnew(tNew_ExToMem),
    .wdPrev(grfWd_ExToMem), .wdStage(dmOut_Mem),
    .we(ifWrGrf_MemToWb), .wa(grfWa_MemToWb), .tnew(tNew_MemToWb), .wd(grfWd_MemToWb)
  );

  assign grfWe_Wb = ifWrGrf_MemToWb;
  assign grfWa_Wb = grfWa_MemToWb;
  assign grfWd_Wb = grfWd_MemToWb;

endmodule

// File: doc/hazard_info_pipe.md
# hazard_info_pipe

Producer side of the hazard/forwarding interface. Carries each instruction's register-write descriptor (write enable, write address, tNew, write data) from decode through the IdToEx, ExToMem and MemToWb pipeline registers. It ages tNew by one per stage and resolves each stage's write data as the value becomes available. It also inserts a bubble into IdToEx on stall and drives the GRF write port from the WB stage. Its outputs are exactly the `*_IdToEx`, `*_ExToMem` and `*_MemToWb` descriptor signals that the hazard unit consumes.

## Interface
- `TNEW_W`, default 5: width of every tNew field.
- `clk` in 1: pipeline clock, rising edge.
- `reset` in 1: synchronous, active-low. Asserted (0) at a rising edge clears all three stage registers.
- `ifStall` in 1: stall request from the hazard unit.
- `ifFlush` in 1: kill the instruction leaving ID, such as an annulled delay slot. Load a bubble exactly as `ifStall` does.
- `ifWrGrf_Id` in 1: the decoded instruction writes the GRF.
- `grfWa_Id` in 5: decoded destination register.
- `tNew_Id` in TNEW_W: decoded tNew. ALU gives 1, load gives 2, jal/link gives 0.
- `grfWd_Id` in 32: data already known in ID, such as PC+8. Meaningful only when `tNew_Id==0`.
- `aluOut_Ex` in 32: EX-stage result.
- `dmOut_Mem` in 32: MEM-stage load data.
- `ifWrGrf_IdToEx`, `ifWrGrf_ExToMem`, `ifWrGrf_MemToWb` out 1: per-stage write enable.
- `grfWa_IdToEx`, `grfWa_ExToMem`, `grfWa_MemToWb` out 5: per-stage destination.
- `tNew_IdToEx`, `tNew_ExToMem`, `tNew_MemToWb` out TNEW_W: remaining cycles until the value exists.
- `grfWd_IdToEx`, `grfWd_ExToMem`, `grfWd_MemToWb` out 32: per-stage resolved write data.
- `grfWe_Wb` out 1: GRF write enable.
- `grfWa_Wb` out 5: GRF write address.
- `grfWd_Wb` out 32: GRF write data.

## Operation
- **Stage register contents.** Each stage register holds {we, wa, tNew, wd}. The bubble value is all-zero: we=0, wa=0, tNew=0, wd=0.
- **IdToEx load rule.** When `ifStall|ifFlush`, load the bubble. Otherwise load:
  - we = `ifWrGrf_Id`
  - wa = `grfWa_Id`
  - tNew = `tNew_Id`
  - wd = `grfWd_Id`
- **ExToMem load rule.** Loads unconditionally on every clock; stall does not freeze it.
  - we, wa copy from IdToEx.
  - tNew = saturating decrement (tNew==0 stays 0).
  - wd = `grfWd_IdToEx` if `tNew_IdToEx==0`, else `aluOut_Ex`.
- **MemToWb load rule.**
  - we, wa copy from ExToMem.
  - tNew = saturating decrement.
  - wd = `grfWd_ExToMem` if `tNew_ExToMem==0`, else `dmOut_Mem`.
- **Write-enable normalisation.** A descriptor with wa==0 is stored with we=0 at IdToEx load, so $0 never appears written downstream.
- **GRF write port.**
  - `grfWe_Wb` = `ifWrGrf_MemToWb`
  - `grfWa_Wb` = `grfWa_MemToWb`
  - `grfWd_Wb` = `grfWd_MemToWb`
- **Simultaneous events.**
  - `ifStall` and `ifFlush` together: bubble.
  - `reset` low overrides everything: all stages become bubbles at that edge.
- **Data-width rule.** No arithmetic on wd; it is a plain 32-bit copy. tNew arithmetic is TNEW_W wide and unsigned, and never wraps below 0.
- **Pipeline FSM.** The pipeline is a fixed 3-deep shift with no FSM beyond the stall/flush select. Each stage's tNew sequence for an instruction is the pure function min-sat(tNew_Id − k) at stage k.

## Timing
- **Reset.** Every output is 0 after a reset edge.
- **Latency.** A descriptor accepted at edge n appears:
  - on `*_IdToEx` after edge n
  - on `*_ExToMem` after edge n+1
  - on `*_MemToWb` and the GRF write port after edge n+2
- **Outputs are registered.** The only combinational paths are the input selects feeding each register; no input reaches an output in the same cycle.
- **Stall behaviour.** Stall for k cycles inserts k consecutive bubbles into IdToEx. The upstream ID stage holds its instruction, and this block re-samples it when stall drops.
- **Reset mid-operation.** Any in-flight descriptor is discarded without a GRF write. This applies even to a descriptor in MemToWb at the reset edge, because the write port then shows the cleared register.

## Structure
- **Package `hazard_pkg`.**
  - `TNEW_W`.
  - tNew constants: `TNEW_LINK=0`, `TNEW_ALU=1`, `TNEW_LOAD=2`.
  - The stage descriptor struct {we, wa, tNew, wd}.
  - The bubble constant.
- **Sub-module `hazard_stage_reg`.** Natural to extract and instantiate three times. It contains:
  - one descriptor register with synchronous active-low clear
  - a bubble-select input
  - tNew saturating decrement enable
  - the tNew==0 data mux, with inputs `wdPrev` and `wdStage`

## Test plan
- **Reset.** Hold `reset`=0 for 2 cycles with nonzero inputs. Required: all 15 outputs are 0, then the first descriptor appears one edge after release.
- **ALU instruction.** Drive we=1, wa=8, tNew=1, `aluOut_Ex`=0x1234 in the EX cycle. Required:
  - IdToEx shows tNew=1.
  - ExToMem shows tNew=0 and wd=0x1234.
  - WB port shows we=1, wa=8, wd=0x1234.
- **Load instruction.** Drive tNew=2, wa=9, `dmOut_Mem`=0xDEADBEEF. Required:
  - tNew goes 2→1→0 across the stages.
  - MemToWb wd=0xDEADBEEF.
  - `aluOut_Ex` garbage does not leak.
- **jal instruction.** Drive tNew=0, wa=31, `grfWd_Id`=0x00003008. Required: wd stays 0x00003008 through all stages, regardless of `aluOut_Ex`/`dmOut_Mem`.
- **Stall and flush.**
  - `ifStall`=1 for 2 cycles behind a load: IdToEx holds the bubble (we=0, wa=0, tNew=0) for 2 cycles while the load advances to WB.
  - `ifFlush` alone also yields a bubble.
- **$0 destination.** Drive we=1, wa=0, tNew=1. Required: we=0 in every stage and `grfWe_Wb` is never asserted.
